// File: rtl/auto_exposure_ctrl_pkg.sv
// Shared encodings for the auto-exposure frame scheduler.
package auto_exposure_ctrl_pkg;

  // Width of the exposure count reported by the exposure-time controller.
  localparam int COUNT_W = 5;

  // Main (exposure/readout) FSM encodings as seen on i_Main_FSM.
  localparam logic [1:0] MAIN_IDLE    = 2'b00;
  localparam logic [1:0] MAIN_EXPOSE  = 2'b01;
  localparam logic [1:0] MAIN_READOUT = 2'b10;

  // Scheduler state encodings, also exported on o_State.
  typedef logic [2:0] ae_state_t;
  localparam ae_state_t ST_IDLE      = 3'd0;
  localparam ae_state_t ST_START     = 3'd1;
  localparam ae_state_t ST_WAIT_BUSY = 3'd2;
  localparam ae_state_t ST_CAPTURE   = 3'd3;
  localparam ae_state_t ST_EVAL      = 3'd4;
  localparam ae_state_t ST_ADJUST    = 3'd5;
  localparam ae_state_t ST_GAP       = 3'd6;

  // Clamp a threshold into the representable sample range.
  function automatic int clamp_level(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    if (v < 0) return 0;
    if (v > top) return top;
    return v;
  endfunction

endpackage

// File: rtl/auto_exposure_ctrl_frame_accumulator.sv
// Per-frame sample accumulator: sums up to NPIX samples and flags extras.
module auto_exposure_ctrl_frame_accumulator #(
  parameter int DATA_W = 8,
  parameter int NPIX   = 4,
  localparam int LOG2_NPIX = $clog2(NPIX),
  localparam int SUM_W     = DATA_W + LOG2_NPIX,
  localparam int CNT_W     = $clog2(NPIX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  assign full = (cnt_q == CNT_W'(NPIX));

  // Accumulate until NPIX samples are held; clear has priority.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (valid && !full) begin
      sum_d = sum_q + SUM_W'(data);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Accumulator and sample counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum      = sum_q;
  assign count    = cnt_q;
  // Combinational: a sample offered while already full is dropped.
  assign overflow = valid && full && !clear;

endmodule

// File: rtl/auto_exposure_ctrl.sv
// Frame scheduler and auto-exposure loop above the exposure/readout core.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | not running, waiting for i_Enable
// START     | issue Init, clear accumulator, arm start timeout
// WAIT_BUSY | wait for main FSM to leave idle
// CAPTURE   | accumulate ADC samples until main FSM returns to idle
// EVAL      | latch mean, check sample count
// ADJUST    | decide on a single increase/decrease pulse
// GAP       | settle time before the next frame
//
// Every output is a flop, so pulses appear the cycle after their state.
module auto_exposure_ctrl
  import auto_exposure_ctrl_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int NPIX          = 4,
  parameter int TARGET        = 128,
  parameter int HYST          = 16,
  parameter int MIN_T         = 2,
  parameter int MAX_T         = 30,
  parameter int GAP_CYCLES    = 8,
  parameter int START_TIMEOUT = 16,
  parameter int FRAME_TIMEOUT = 1023
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Enable,
  input  logic [1:0]         i_Main_FSM,
  input  logic [COUNT_W-1:0] i_count_time,
  input  logic               i_ADC_valid,
  input  logic [DATA_W-1:0]  i_ADC_data,
  output logic               o_Init,
  output logic               o_Exp_increase,
  output logic               o_Exp_decrease,
  output logic               o_Frame_done,
  output logic [DATA_W-1:0]  o_Avg,
  output logic               o_Error,
  output logic [2:0]         o_State
);

  localparam int LOG2_NPIX = $clog2(NPIX);
  localparam int SUM_W     = DATA_W + LOG2_NPIX;
  localparam int CNT_W     = $clog2(NPIX + 1);

  localparam int TMAX_A  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TMAX    = (FRAME_TIMEOUT > TMAX_A) ? FRAME_TIMEOUT : TMAX_A;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [DATA_W-1:0]  THR_LO = DATA_W'(clamp_level(TARGET - HYST, DATA_W));
  localparam logic [DATA_W-1:0]  THR_HI = DATA_W'(clamp_level(TARGET + HYST, DATA_W));
  localparam logic [COUNT_W-1:0] MIN_C  = COUNT_W'(MIN_T);
  localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_T);

  // Timer reload values: the timer counts down and expires at zero.
  localparam logic [TIMER_W-1:0] LD_START = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LD_FRAME = TIMER_W'(FRAME_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LD_GAP   = TIMER_W'(GAP_CYCLES - 1);

  ae_state_t          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               init_q, init_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  avg_q, avg_d;
  logic               err_q, err_d;
  logic               err_set;

  logic [SUM_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_overflow;
  logic [DATA_W-1:0] mean;

  auto_exposure_ctrl_frame_accumulator #(
    .DATA_W (DATA_W),
    .NPIX   (NPIX)
  ) u_acc (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .clear    (state_q == ST_START),
    .valid    (i_ADC_valid && (state_q == ST_CAPTURE)),
    .data     (i_ADC_data),
    .sum      (acc_sum),
    .count    (acc_count),
    .overflow (acc_overflow)
  );

  assign mean = acc_sum[SUM_W-1:LOG2_NPIX];

  // Next-state, timer and output decode for the frame scheduler.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    avg_d   = avg_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Enable) state_d = ST_START;
      end
      ST_START: begin
        timer_d = LD_START;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_Main_FSM != MAIN_IDLE) begin
          timer_d = LD_FRAME;
          state_d = ST_CAPTURE;
        end else if (timer_q == '0) begin
          err_set = 1'b1;
          timer_d = LD_GAP;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (acc_overflow) err_set = 1'b1;
        if (i_Main_FSM == MAIN_IDLE) begin
          state_d = ST_EVAL;
        end else if (timer_q == '0) begin
          err_set = 1'b1;
          timer_d = LD_GAP;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_EVAL: begin
        avg_d = mean;
        if (acc_count != CNT_W'(NPIX)) begin
          err_set = 1'b1;
          timer_d = LD_GAP;
          state_d = ST_GAP;
        end else begin
          state_d = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        inc_d   = (mean < THR_LO) && (i_count_time < MAX_C);
        dec_d   = (mean > THR_HI) && (i_count_time > MIN_C);
        timer_d = LD_GAP;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (timer_q == '0) state_d = i_Enable ? ST_START : ST_IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    init_d = (state_q == ST_START);
    done_d = (state_q == ST_EVAL);
    err_d  = err_q | err_set;
  end

  // State, timer and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      init_q  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      avg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      init_q  <= init_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      avg_q   <= avg_d;
      err_q   <= err_d;
    end
  end

  assign o_Init         = init_q;
  assign o_Exp_increase = inc_q;
  assign o_Exp_decrease = dec_q;
  assign o_Frame_done   = done_q;
  assign o_Avg          = avg_q;
  assign o_Error        = err_q;
  assign o_State        = state_q;

endmodule
